spi_inst_receiver: RTL and testbench
====================================

Name: spi_inst_receiver

Overview:
SPI slave front end that receives N-bit task instructions from the Raspberry Pi and presents them to the task manager as RPi_inst. It also drives the execute_task handshake. Status (inst_valid, job_done, error flags) is returned to the Pi on MISO during every frame. It sits directly upstream of the task manager, and all of its logic runs in the FPGA clk domain.

Parameters:
N, 80, instruction width in bits; the frame length in SCLK rising edges.
SYNC_STAGES, 2, synchronizer depth for sclk, cs_n and mosi.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock from the Pi, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
cs_n  input  1  SPI chip select, active low.
mosi  input  1  serial data in, MSB first.
miso  output  1  serial status out, MSB first.
RPi_inst  output  N  latched instruction for the task manager.
execute_task  output  1  request to the task manager to start RPi_inst.
inst_valid  input  1  task manager's validity check of RPi_inst.
job_done  input  1  task manager idle/done flag (1 = idle).
busy  output  1  high from frame accept until the job completes or is rejected.
frame_count  output  8  count of accepted frames, wraps 255 -> 0.

Behaviour:
- Reset values: RPi_inst=0, execute_task=0, busy=0, miso=0, frame_count=0, all flags=0, state=IDLE, bit counter=0.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk. The Pi must keep SCLK at or below clk/8.
- Shift-in: on each sclk rising edge while cs_n is low, shift mosi into an N-bit shift register (LSB end) and increment a 7-bit bit counter, saturating at N+1.
- Status byte: {job_done, inst_valid, busy, len_err, busy_err, rej_err, 2'b00}. It is loaded into the MISO shift register on the cs_n falling edge. It shifts on sclk falling edges; bit 7 is on miso before the first rising edge. After 8 bits, miso=0.
- Frame end (cs_n rising edge):
  - bit count == N and state IDLE: copy the shift register to RPi_inst on the next clk, clear len_err, rej_err and busy_err, increment frame_count, go to ISSUE.
  - bit count != N: discard the frame, set len_err, RPi_inst unchanged.
  - state != IDLE: discard the frame, set busy_err.
  - In all cases the bit counter clears.
- State machine:
  - IDLE: execute_task=0, busy=0.
  - ISSUE: execute_task=1, busy=1.
    - job_done=0 seen: drop execute_task next cycle, go to WAIT_DONE (the task manager accepted).
    - inst_valid=0 seen while job_done=1: drop execute_task, set rej_err, go to IDLE.
    - Both low in the same cycle: treat as accepted.
  - WAIT_DONE: execute_task=0, busy=1. On job_done=1, go to IDLE.
  - RPi_inst is held constant from ISSUE entry until the next accepted frame.
- Latency: cs_n rising at the pin to execute_task=1 is at most SYNC_STAGES+2 clk cycles.
- cs_n glitch with no sclk edges: counts as a 0-bit frame; len_err is set.
- Reset mid-frame or mid-job: everything returns to reset values immediately. A partial frame is lost.

Test Plan:
- Valid frame: shift 80 bits 0xFF_000010_000020_000030; task manager drops job_done 1 cycle after execute_task and raises it 50 cycles later. Required: RPi_inst=0xFF000010000020000030, execute_task high until job_done=0, busy high throughout, frame_count=1, IDLE at the end.
- Short frame: 72 bits, then cs_n high. Required: no execute_task, RPi_inst unchanged, next frame's first MISO byte = 0xD0 (job_done=1, inst_valid=1, len_err=1).
- Rejected instruction: opcode 0x01, inst_valid=0, job_done=1. Required: execute_task pulses at most 1 cycle, rej_err=1, busy=0, status byte bit 2 set.
- Frame while busy: a second valid frame during WAIT_DONE. Required: RPi_inst keeps the first value, busy_err=1, frame_count unchanged. A later valid frame clears busy_err.
- MISO readback: job_done=1, inst_valid=1, idle, no errors. Required: first 8 miso bits 1,1,0,0,0,0,0,0, then 0s.
- Async reset asserted after 40 bits and in WAIT_DONE. Required: all outputs 0 within the reset assertion; the next full frame is accepted normally.

Source files
------------

// File: rtl/spi_inst_receiver_if.sv
// SPI pins plus the task-manager handshake for spi_inst_receiver.
// The receiver uses the slave modport; the Pi/task-manager side uses master.
interface spi_inst_receiver_if #(
   parameter int N = 80
);
   logic         sclk;
   logic         cs_n;
   logic         mosi;
   logic         miso;
   logic [N-1:0] RPi_inst;
   logic         execute_task;
   logic         inst_valid;
   logic         job_done;
   logic         busy;
   logic [7:0]   frame_count;

   modport slave (
      input  sclk, cs_n, mosi, inst_valid, job_done,
      output miso, RPi_inst, execute_task, busy, frame_count
   );

   modport master (
      output sclk, cs_n, mosi, inst_valid, job_done,
      input  miso, RPi_inst, execute_task, busy, frame_count
   );
endinterface

// File: rtl/spi_inst_receiver.sv
// SPI mode-0 slave that collects N-bit instructions, hands them to the task
// manager through execute_task, and returns a status byte on MISO.
module spi_inst_receiver #(
   parameter int N           = 80,
   parameter int SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               reset_n,
   spi_inst_receiver_if.slave bus
);
   localparam int CW = $clog2(N + 2);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [N-1:0]           shreg, inst_q;
   logic [CW-1:0]          bit_cnt;
   logic [7:0]             frame_cnt, miso_sr;
   logic                   len_err, busy_err, rej_err;
   logic                   accept, reject, exec_w, busy_w;

   // cs_n synchronizer resets to the deasserted level so reset release is not a frame end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   assign accept = cs_rise && (bit_cnt == CW'(N)) && (state_q == IDLE);
   assign reject = (state_q == ISSUE) && bus.job_done && !bus.inst_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         inst_q    <= '0;
         frame_cnt <= '0;
         miso_sr   <= '0;
         len_err   <= 1'b0;
         busy_err  <= 1'b0;
         rej_err   <= 1'b0;
      end else begin
         if (cs_rise)
            bit_cnt <= '0;
         else if (sclk_rise && !cs_s) begin
            shreg <= {shreg[N-2:0], mosi_s};
            if (bit_cnt != CW'(N + 1))
               bit_cnt <= bit_cnt + 1'b1;
         end

         // status is snapshotted at frame start; leftover bits are dropped at frame end
         if (cs_fall)
            miso_sr <= {bus.job_done, bus.inst_valid, busy_w, len_err, busy_err, rej_err, 2'b00};
         else if (cs_rise)
            miso_sr <= '0;
         else if (sclk_fall && !cs_s)
            miso_sr <= {miso_sr[6:0], 1'b0};

         if (accept) begin
            inst_q    <= shreg;
            frame_cnt <= frame_cnt + 8'd1;
            len_err   <= 1'b0;
            busy_err  <= 1'b0;
            rej_err   <= 1'b0;
         end else begin
            if (cs_rise && bit_cnt != CW'(N)) len_err  <= 1'b1;
            if (cs_rise && state_q != IDLE)   busy_err <= 1'b1;
            if (reject)                       rej_err  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // job_done low wins over inst_valid low: the task manager already took the job
   always_comb begin
      state_d = state_q;
      exec_w  = 1'b0;
      busy_w  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = ISSUE;
         end
         ISSUE: begin
            exec_w = 1'b1;
            busy_w = 1'b1;
            if (!bus.job_done)        state_d = WAIT_DONE;
            else if (!bus.inst_valid) state_d = IDLE;
         end
         WAIT_DONE: begin
            busy_w = 1'b1;
            if (bus.job_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.miso         = miso_sr[7];
   assign bus.RPi_inst     = inst_q;
   assign bus.execute_task = exec_w;
   assign bus.busy         = busy_w;
   assign bus.frame_count  = frame_cnt;
endmodule

// File: tb/tb_spi_inst_receiver.sv
// Directed bench for spi_inst_receiver: SPI master and task-manager model
// driving hand-computed frames, status bytes and handshake expectations.
module tb_spi_inst_receiver;
   localparam int N  = 80;
   localparam int TH = 60;  // SCLK half period, 6 clk cycles

   logic clk = 1'b0;
   logic reset_n;
   int   n_vec = 0;
   int   n_bad = 0;
   int   tm_hold = 50;
   bit   tm_en = 1'b1;
   bit   tm_abort = 1'b0;

   spi_inst_receiver_if #(.N(N)) bus ();

   spi_inst_receiver #(.N(N), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   localparam logic [N-1:0] FA = 80'hFF_000010_000020_000030;
   localparam logic [N-1:0] FB = 80'h01_000000_000000_000001;
   localparam logic [N-1:0] FC = 80'h02_0000AA_0000BB_0000CC;
   localparam logic [N-1:0] FD = 80'h03_123456_789ABC_DEF012;
   localparam logic [N-1:0] FE = 80'h04_111111_222222_333333;
   localparam logic [N-1:0] FF = 80'h05_AAAAAA_555555_0F0F0F;
   localparam logic [N-1:0] FG = 80'h06_DEADBE_EFCAFE_BABE00;
   localparam logic [N-1:0] FH = 80'h07_000000_000000_0000FF;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Task manager: drop job_done one cycle after seeing execute_task, hold it low tm_hold cycles
   initial begin
      bus.job_done = 1'b1;
      forever begin
         @(negedge clk);
         if (tm_en && bus.execute_task && bus.job_done) begin
            @(negedge clk);
            bus.job_done = 1'b0;
            for (int k = 0; k < tm_hold && !tm_abort; k++) @(negedge clk);
            bus.job_done = 1'b1;
         end
      end
   end

   // MSB-first mode-0 master; rx collects the first 16 MISO bits
   task automatic spi_frame(input int nbits, input logic [N-1:0] data, input bit end_cs,
                            output logic [15:0] rx);
      rx = '0;
      @(negedge clk);
      bus.cs_n = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = data[N-1-i];
         #(TH);
         if (i < 16) rx[15-i] = bus.miso;
         bus.sclk = 1'b1;
         #(TH);
         bus.sclk = 1'b0;
      end
      #(TH);
      bus.mosi = 1'b0;
      if (end_cs) bus.cs_n = 1'b1;
   endtask

   task automatic wait_exec(output int cyc);
      cyc = 0;
      for (int k = 0; k < 40 && !bus.execute_task; k++) @(negedge clk);
      while (bus.execute_task && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int lim);
      for (int k = 0; k < lim && bus.busy; k++) @(negedge clk);
      chk("idle_reached", bus.busy, 1'b0);
   endtask

   logic [15:0] rx;
   int          ec;

   initial begin
      reset_n        = 1'b0;
      bus.sclk       = 1'b0;
      bus.cs_n       = 1'b1;
      bus.mosi       = 1'b0;
      bus.inst_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_inst",  bus.RPi_inst, '0);
      chk("rst_exec",  bus.execute_task, 1'b0);
      chk("rst_busy",  bus.busy, 1'b0);
      chk("rst_miso",  bus.miso, 1'b0);
      chk("rst_count", bus.frame_count, 8'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // Valid frame; idle status with no errors reads back 0xC0 then zeros
      tm_hold = 50;
      spi_frame(80, FA, 1'b1, rx);
      chk("a_miso16", rx, 16'hC000);
      wait_exec(ec);
      chk("a_exec_cyc", ec, 2);
      chk("a_inst", bus.RPi_inst, FA);
      chk("a_busy_wait", bus.busy, 1'b1);
      wait_idle(200);
      chk("a_count", bus.frame_count, 8'd1);

      // Short frame is discarded
      spi_frame(72, FC, 1'b1, rx);
      chk("s_status", rx[15:8], 8'hC0);
      wait_exec(ec);
      chk("s_no_exec", ec, 0);
      chk("s_inst", bus.RPi_inst, FA);
      chk("s_count", bus.frame_count, 8'd1);

      // Next frame shows len_err and clears it
      spi_frame(80, FC, 1'b1, rx);
      chk("c_status", rx[15:8], 8'hD0);
      wait_exec(ec);
      chk("c_exec_cyc", ec, 2);
      wait_idle(200);
      chk("c_inst", bus.RPi_inst, FC);
      chk("c_count", bus.frame_count, 8'd2);

      // Rejected instruction: task manager stays idle and flags it invalid
      tm_en = 1'b0;
      bus.inst_valid = 1'b0;
      spi_frame(80, FB, 1'b1, rx);
      chk("b_status", rx[15:8], 8'h80);
      wait_exec(ec);
      chk("b_exec_cyc", ec, 1);
      chk("b_busy", bus.busy, 1'b0);
      chk("b_count", bus.frame_count, 8'd3);
      bus.inst_valid = 1'b1;
      tm_en = 1'b1;

      // Long job; status shows rej_err in bit 2
      tm_hold = 3000;
      spi_frame(80, FD, 1'b1, rx);
      chk("d_status", rx[15:8], 8'hC4);
      wait_exec(ec);
      chk("d_exec_cyc", ec, 2);
      chk("d_count", bus.frame_count, 8'd4);

      // Frame while in WAIT_DONE is discarded
      spi_frame(80, FE, 1'b1, rx);
      chk("e_status", rx[15:8], 8'h60);
      wait_exec(ec);
      chk("e_no_exec", ec, 0);
      chk("e_inst", bus.RPi_inst, FD);
      chk("e_count", bus.frame_count, 8'd4);
      chk("e_busy", bus.busy, 1'b1);
      wait_idle(4000);

      // Later valid frame reports and then clears busy_err
      tm_hold = 50;
      spi_frame(80, FF, 1'b1, rx);
      chk("f_status", rx[15:8], 8'hC8);
      wait_exec(ec);
      chk("f_exec_cyc", ec, 2);
      wait_idle(200);
      chk("f_inst", bus.RPi_inst, FF);
      chk("f_count", bus.frame_count, 8'd5);

      // Reset after 40 bits of a frame
      spi_frame(40, FG, 1'b0, rx);
      chk("p_status", rx[15:8], 8'hC0);
      reset_n = 1'b0;
      #1;
      chk("p_rst_inst",  bus.RPi_inst, '0);
      chk("p_rst_count", bus.frame_count, 8'd0);
      chk("p_rst_busy",  bus.busy, 1'b0);
      chk("p_rst_miso",  bus.miso, 1'b0);
      bus.cs_n = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // Full frame accepted after reset, then reset during WAIT_DONE
      tm_hold = 3000;
      spi_frame(80, FG, 1'b1, rx);
      chk("g_miso16", rx, 16'hC000);
      wait_exec(ec);
      chk("g_exec_cyc", ec, 2);
      chk("g_count", bus.frame_count, 8'd1);
      chk("g_inst", bus.RPi_inst, FG);
      repeat (20) @(negedge clk);
      chk("g_busy", bus.busy, 1'b1);
      reset_n = 1'b0;
      tm_abort = 1'b1;
      #1;
      chk("w_rst_busy",  bus.busy, 1'b0);
      chk("w_rst_exec",  bus.execute_task, 1'b0);
      chk("w_rst_inst",  bus.RPi_inst, '0);
      chk("w_rst_count", bus.frame_count, 8'd0);
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      tm_abort = 1'b0;
      repeat (4) @(negedge clk);

      // cs_n glitch with no SCLK is a 0-bit frame
      bus.cs_n = 1'b0;
      repeat (6) @(negedge clk);
      bus.cs_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("gl_no_exec", bus.execute_task, 1'b0);
      tm_hold = 50;
      spi_frame(80, FH, 1'b1, rx);
      chk("h_status", rx[15:8], 8'hD0);
      wait_exec(ec);
      chk("h_exec_cyc", ec, 2);
      wait_idle(200);
      chk("h_count", bus.frame_count, 8'd1);
      chk("h_inst", bus.RPi_inst, FH);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
